i2c_target: RTL and testbench



---
 rtl/i2c_target_pkg.sv | 26 ++
 rtl/i2c_target_sync.sv | 82 ++++++++
 rtl/i2c_target.sv | 176 +++++++++++++++++
 tb/tb_i2c_target.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target: FSM states, bus-level ACK values,
// byte width and the majority helper used by the optional input glitch filter.
package i2c_target_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ACK_ADDR,
        PTR,
        ACK_PTR,
        WRITE,
        ACK_WR,
        READ,
        MACK,
        WAIT_STOP
    } state_t;

    localparam logic ACK       = 1'b0;
    localparam logic NACK      = 1'b1;
    localparam int   BYTE_BITS = 8;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/i2c_target_sync.sv
// SCL/SDA synchronizer, optional 3-sample majority filter (I2C_TARGET_GLITCH_FILTER_EN),
// and SCL edge / START / STOP detection on the cleaned-up lines.
module i2c_target_sync
    import i2c_target_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_scl,
    input  logic i_sda,
    output logic sda_bit,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    localparam int STAGES = SYNC_STAGES + 3;
`else
    localparam int STAGES = SYNC_STAGES + 1;
`endif

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_s, sda_s, scl_q, sda_q;
    logic [STAGES:0]        vld_pipe;
    logic                   ok;

    // vld_pipe masks events until every stage holds a real post-reset sample,
    // so a reset in the middle of a transfer cannot fabricate a START.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            vld_pipe <= '0;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], i_scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], i_sda};
            vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [1:0] scl_hist, sda_hist;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            scl_hist <= '1;
            sda_hist <= '1;
            scl_s    <= 1'b1;
            sda_s    <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[SYNC_STAGES-1]};
            sda_hist <= {sda_hist[0], sda_sync[SYNC_STAGES-1]};
            scl_s    <= maj3(scl_sync[SYNC_STAGES-1], scl_hist[0], scl_hist[1]);
            sda_s    <= maj3(sda_sync[SYNC_STAGES-1], sda_hist[0], sda_hist[1]);
        end
    end
`else
    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_s;
            sda_q <= sda_s;
        end
    end

    assign ok        = vld_pipe[STAGES];
    assign sda_bit   = sda_s;
    assign scl_rise  = ok &  scl_s & ~scl_q;
    assign scl_fall  = ok & ~scl_s &  scl_q;
    assign start_det = ok &  scl_s &  scl_q &  sda_q & ~sda_s;
    assign stop_det  = ok &  scl_s &  scl_q & ~sda_q &  sda_s;

endmodule

// File: rtl/i2c_target.sv
// I2C target exposing a byte-wide register window: pointer byte, auto-incrementing
// writes and reads. Optional input glitch filter via I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR    = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda,
    output logic       o_sda_oe,
    output logic [7:0] o_reg_addr,
    output logic [7:0] o_reg_wdata,
    output logic       o_reg_we,
    output logic       o_reg_re,
    input  logic [7:0] i_reg_rdata,
    output logic       o_busy
);

    logic       sda_bit, scl_rise, scl_fall, start_det, stop_det;
    state_t     state, state_n;
    logic [3:0] bit_cnt, bit_cnt_n;
    logic [7:0] shreg, shreg_n, byte_in, addr_n, wdata_n;
    logic       rw, rw_n, ack_on, ack_on_n, oe_n, busy_n, we_n, re_n, re_d;

    i2c_target_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_scl    (i_scl),
        .i_sda    (i_sda),
        .sda_bit  (sda_bit),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det)
    );

    assign o_sda = 1'b0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            rw          <= 1'b0;
            ack_on      <= 1'b0;
            o_sda_oe    <= 1'b1;
            o_reg_addr  <= '0;
            o_reg_wdata <= '0;
            o_reg_we    <= 1'b0;
            o_reg_re    <= 1'b0;
            o_busy      <= 1'b0;
            re_d        <= 1'b0;
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            shreg       <= shreg_n;
            rw          <= rw_n;
            ack_on      <= ack_on_n;
            o_sda_oe    <= oe_n;
            o_reg_addr  <= addr_n;
            o_reg_wdata <= wdata_n;
            o_reg_we    <= we_n;
            o_reg_re    <= re_n;
            o_busy      <= busy_n;
            re_d        <= o_reg_re;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        rw_n      = rw;
        ack_on_n  = ack_on;
        oe_n      = o_sda_oe;
        addr_n    = o_reg_addr;
        wdata_n   = o_reg_wdata;
        busy_n    = o_busy;
        we_n      = 1'b0;
        re_n      = 1'b0;
        byte_in   = {shreg[BYTE_BITS-2:0], sda_bit};

        // Pointer advances the cycle after a write strobe; read data lands
        // the cycle after the read strobe.
        if (o_reg_we) addr_n = o_reg_addr + 8'd1;
        if (re_d) shreg_n = i_reg_rdata;

        if (start_det) begin
            state_n   = ADDR;
            bit_cnt_n = '0;
            ack_on_n  = 1'b0;
            oe_n      = NACK;
        end else if (stop_det) begin
            state_n   = IDLE;
            bit_cnt_n = '0;
            ack_on_n  = 1'b0;
            oe_n      = NACK;
            busy_n    = 1'b0;
        end else begin
            case (state)
                ADDR, PTR, WRITE: if (scl_rise) begin
                    shreg_n   = byte_in;
                    bit_cnt_n = bit_cnt + 4'd1;
                    if (bit_cnt == 4'(BYTE_BITS - 1)) begin
                        bit_cnt_n = '0;
                        if (state == ADDR) begin
                            if (byte_in[7:1] == I2C_ADDR) begin
                                state_n = ACK_ADDR;
                                rw_n    = byte_in[0];
                                re_n    = byte_in[0];
                                busy_n  = 1'b1;
                            end else begin
                                state_n = IDLE;
                            end
                        end else if (state == PTR) begin
                            addr_n  = byte_in;
                            state_n = ACK_PTR;
                        end else begin
                            wdata_n = byte_in;
                            we_n    = 1'b1;
                            state_n = ACK_WR;
                        end
                    end
                end
                // First fall after the byte pulls SDA low; the following fall
                // ends the ACK slot and hands over to the data phase.
                ACK_ADDR, ACK_PTR, ACK_WR: if (scl_fall) begin
                    if (!ack_on) begin
                        oe_n     = ACK;
                        ack_on_n = 1'b1;
                    end else begin
                        ack_on_n  = 1'b0;
                        oe_n      = NACK;
                        bit_cnt_n = '0;
                        if (state == ACK_ADDR && rw) begin
                            oe_n      = shreg[BYTE_BITS-1];
                            shreg_n   = {shreg[BYTE_BITS-2:0], 1'b0};
                            bit_cnt_n = 4'd1;
                            state_n   = READ;
                        end else if (state == ACK_ADDR) begin
                            state_n = PTR;
                        end else begin
                            state_n = WRITE;
                        end
                    end
                end
                READ: if (scl_fall) begin
                    if (bit_cnt == 4'(BYTE_BITS)) begin
                        oe_n      = NACK;
                        bit_cnt_n = '0;
                        state_n   = MACK;
                    end else begin
                        oe_n      = shreg[BYTE_BITS-1];
                        shreg_n   = {shreg[BYTE_BITS-2:0], 1'b0};
                        bit_cnt_n = bit_cnt + 4'd1;
                    end
                end
                MACK: if (scl_rise) begin
                    if (sda_bit == ACK) begin
                        addr_n  = o_reg_addr + 8'd1;
                        re_n    = 1'b1;
                        state_n = READ;
                    end else begin
                        state_n = WAIT_STOP;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged I2C controller, register-file model, vector tables,
// hand-written corner sequences and randomized write/read-back against a memory model.
module tb_i2c_target;

    localparam int Q = 8;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_scl, i_sda;
    logic       o_sda, o_sda_oe;
    logic [7:0] o_reg_addr, o_reg_wdata;
    logic       o_reg_we, o_reg_re, o_busy;
    logic [7:0] i_reg_rdata;
    logic       scl_drv, sda_drv;

    logic [7:0]  mem[256];
    logic [7:0]  ref_mem[256];
    logic [15:0] we_q[$];
    logic [7:0]  re_q[$];
    logic        oe_low_seen;
    logic [7:0]  wbuf[4];
    logic [7:0]  rbuf[4];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 i_clk = ~i_clk;

    assign i_scl = scl_drv;
    assign i_sda = sda_drv & (o_sda_oe | o_sda);

    i2c_target dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_scl      (i_scl),
        .i_sda      (i_sda),
        .o_sda      (o_sda),
        .o_sda_oe   (o_sda_oe),
        .o_reg_addr (o_reg_addr),
        .o_reg_wdata(o_reg_wdata),
        .o_reg_we   (o_reg_we),
        .o_reg_re   (o_reg_re),
        .i_reg_rdata(i_reg_rdata),
        .o_busy     (o_busy)
    );

    // Register file behind the window: read data valid the cycle after re.
    always @(posedge i_clk) if (o_reg_re) i_reg_rdata <= mem[o_reg_addr];

    always @(negedge i_clk) begin
        if (o_reg_we) begin
            we_q.push_back({o_reg_addr, o_reg_wdata});
            mem[o_reg_addr] = o_reg_wdata;
        end
        if (o_reg_re) re_q.push_back(o_reg_addr);
        if (!o_sda_oe) oe_low_seen = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic bus_start();
        sda_drv = 1'b1; wait_n(Q);
        scl_drv = 1'b1; wait_n(Q);
        sda_drv = 1'b0; wait_n(Q);
        scl_drv = 1'b0; wait_n(Q);
    endtask

    task automatic bus_stop();
        sda_drv = 1'b0; wait_n(Q);
        scl_drv = 1'b1; wait_n(Q);
        sda_drv = 1'b1; wait_n(Q);
    endtask

    task automatic write_bit(input logic b, input logic g);
        sda_drv = b;
        if (g) begin
            wait_n(2); scl_drv = 1'b1; wait_n(1); scl_drv = 1'b0; wait_n(Q - 3);
        end else begin
            wait_n(Q);
        end
        scl_drv = 1'b1; wait_n(2 * Q);
        scl_drv = 1'b0; wait_n(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_drv = 1'b1; wait_n(Q);
        scl_drv = 1'b1; wait_n(Q);
        b = i_sda;      wait_n(Q);
        scl_drv = 1'b0; wait_n(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack, input int gbit);
        for (int i = 7; i >= 0; i--) write_bit(d[i], i == gbit);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic mack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(mack, 1'b0);
    endtask

    task automatic do_write(input logic [7:0] ptr, input int n);
        logic ack;
        bus_start();
        write_byte(8'h84, ack, -1); check("wr_addr_ack", 32'(ack), 0);
        write_byte(ptr, ack, -1);   check("wr_ptr_ack", 32'(ack), 0);
        for (int k = 0; k < n; k++) begin
            write_byte(wbuf[k], ack, -1);
            check("wr_data_ack", 32'(ack), 0);
            ref_mem[8'(ptr + k)] = wbuf[k];
        end
        check("busy_in_wr", 32'(o_busy), 1);
        bus_stop();
        wait_n(4);
        check("busy_after_stop", 32'(o_busy), 0);
    endtask

    task automatic do_read(input logic [7:0] ptr, input int n);
        logic ack;
        re_q.delete();
        bus_start();
        write_byte(8'h84, ack, -1); check("rd_addr_ack", 32'(ack), 0);
        write_byte(ptr, ack, -1);   check("rd_ptr_ack", 32'(ack), 0);
        bus_start();
        write_byte(8'h85, ack, -1); check("rd_addr_r_ack", 32'(ack), 0);
        for (int k = 0; k < n; k++) read_byte(rbuf[k], (k == n - 1) ? 1'b1 : 1'b0);
        wait_n(2);
        check("oe_after_nack", 32'(o_sda_oe), 1);
        bus_stop();
        wait_n(4);
        check("re_count", re_q.size(), 32'(n));
        for (int k = 0; k < n; k++) begin
            check("rd_byte", 32'(rbuf[k]), 32'(ref_mem[8'(ptr + k)]));
            check("re_addr", 32'(re_q[k]), 32'(8'(ptr + k)));
        end
    endtask

    typedef struct {
        logic [7:0] abyte;
        logic       exp_ack;
    } ad_vec_t;

    typedef struct {
        logic [7:0] ptr, d0, d1, a0, a1;
    } wr_vec_t;

    ad_vec_t av[5];
    wr_vec_t wv[3];

    initial begin
        logic ack;
        logic b;
        logic [7:0] ptr;
        int n;

        av[0] = '{8'h84, 1'b0};
        av[1] = '{8'h90, 1'b1};
        av[2] = '{8'hC4, 1'b1};
        av[3] = '{8'h86, 1'b1};
        av[4] = '{8'h04, 1'b1};
        wv[0] = '{8'h10, 8'hA5, 8'h5A, 8'h10, 8'h11};
        wv[1] = '{8'hFF, 8'h11, 8'h22, 8'hFF, 8'h00};
        wv[2] = '{8'h7F, 8'h00, 8'hFF, 8'h7F, 8'h80};

        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        oe_low_seen = 1'b0;
        scl_drv = 1'b1;
        sda_drv = 1'b1;
        i_rst   = 1'b1;
        wait_n(4);
        check("rst_oe", 32'(o_sda_oe), 1);
        check("rst_sda", 32'(o_sda), 0);
        check("rst_addr", 32'(o_reg_addr), 0);
        check("rst_wdata", 32'(o_reg_wdata), 0);
        check("rst_we", 32'(o_reg_we), 0);
        check("rst_re", 32'(o_reg_re), 0);
        check("rst_busy", 32'(o_busy), 0);
        i_rst = 1'b0;
        wait_n(8);

        // Address match table: ACK, busy and SDA drive only for our address.
        for (int i = 0; i < 5; i++) begin
            we_q.delete(); re_q.delete();
            oe_low_seen = 1'b0;
            bus_start();
            write_byte(av[i].abyte, ack, -1);
            check("addr_ack", 32'(ack), 32'(av[i].exp_ack));
            check("addr_busy", 32'(o_busy), 32'(!av[i].exp_ack));
            check("addr_oe_low", 32'(oe_low_seen), 32'(!av[i].exp_ack));
            bus_stop();
            wait_n(4);
            check("addr_busy_stop", 32'(o_busy), 0);
            check("addr_no_strobes", we_q.size() + re_q.size(), 0);
        end

        // Write table: strobes with auto-increment and 0xFF -> 0x00 wrap.
        for (int i = 0; i < 3; i++) begin
            we_q.delete();
            wbuf[0] = wv[i].d0;
            wbuf[1] = wv[i].d1;
            do_write(wv[i].ptr, 2);
            check("we_count", we_q.size(), 2);
            check("we0", 32'(we_q[0]), 32'({wv[i].a0, wv[i].d0}));
            check("we1", 32'(we_q[1]), 32'({wv[i].a1, wv[i].d1}));
            check("addr_after_wr", 32'(o_reg_addr), 32'(8'(wv[i].a1 + 8'd1)));
        end

        // Read with repeated START and controller ACK then NACK.
        mem[8'h20] = 8'h3C; ref_mem[8'h20] = 8'h3C;
        mem[8'h21] = 8'hC3; ref_mem[8'h21] = 8'hC3;
        do_read(8'h20, 2);
        check("rd_0x3C", 32'(rbuf[0]), 'h3C);
        check("rd_0xC3", 32'(rbuf[1]), 'hC3);

        // STOP after 4 data bits discards the byte; next transfer still ACKed.
        we_q.delete();
        bus_start();
        write_byte(8'h84, ack, -1);
        write_byte(8'h30, ack, -1);
        write_bit(1'b1, 1'b0); write_bit(1'b0, 1'b0);
        write_bit(1'b1, 1'b0); write_bit(1'b1, 1'b0);
        bus_stop();
        wait_n(2);
        check("abort_no_we", we_q.size(), 0);
        check("abort_oe", 32'(o_sda_oe), 1);
        check("abort_busy", 32'(o_busy), 0);
        bus_start();
        write_byte(8'h84, ack, -1);
        check("abort_reack", 32'(ack), 0);
        bus_stop();

        // Reset in the middle of a read while the target drives a 0 bit.
        mem[8'h40] = 8'h00; ref_mem[8'h40] = 8'h00;
        we_q.delete();
        bus_start();
        write_byte(8'h84, ack, -1);
        write_byte(8'h40, ack, -1);
        bus_start();
        write_byte(8'h85, ack, -1);
        for (int i = 0; i < 3; i++) read_bit(b);
        check("rd_driving_low", 32'(o_sda_oe), 0);
        i_rst = 1'b1;
        wait_n(1);
        check("midrst_oe", 32'(o_sda_oe), 1);
        check("midrst_busy", 32'(o_busy), 0);
        check("midrst_addr", 32'(o_reg_addr), 0);
        check("midrst_re", 32'(o_reg_re), 0);
        i_rst = 1'b0;
        wait_n(8);
        bus_stop();
        bus_start();
        write_byte(8'h84, ack, -1);
        check("midrst_reack", 32'(ack), 0);
        bus_stop();
        wait_n(4);
        check("midrst_no_we", we_q.size(), 0);

`ifdef I2C_TARGET_GLITCH_FILTER_EN
        // One-cycle SCL pulse inside a data bit must not shift an extra bit.
        we_q.delete();
        bus_start();
        write_byte(8'h84, ack, -1);
        write_byte(8'h60, ack, -1);
        write_byte(8'h96, ack, 3);
        check("glitch_ack", 32'(ack), 0);
        bus_stop();
        wait_n(4);
        check("glitch_we_count", we_q.size(), 1);
        check("glitch_we", 32'(we_q[0]), 'h6096);
        ref_mem[8'h60] = 8'h96;
`endif

        // Randomized write then read-back against the memory model.
        for (int it = 0; it < 5; it++) begin
            ptr = 8'($urandom);
            n   = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom);
            we_q.delete();
            do_write(ptr, n);
            check("rnd_we_count", we_q.size(), 32'(n));
            for (int k = 0; k < n; k++)
                check("rnd_we", 32'(we_q[k]), 32'({8'(ptr + k), wbuf[k]}));
            do_read(ptr, n);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
